brightness_oe_scheduler: RTL

BRIGHTNESS_OE_SCHEDULER -- requirements
Module: brightness_oe_scheduler

---
 rtl/brightness_oe_scheduler.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/brightness_oe_scheduler.sv
// Row output-enable scheduler: converts the active bit-plane, global dim
// and timing mode into a blanked, fixed-length OE window per row latch.
package params_pkg;
    localparam int BRIGHTNESS_LEVELS       = 4;
    localparam int BRIGHTNESS_BASE_TIMEOUT = 8;
endpackage

module brightness_oe_scheduler #(
    parameter int BRIGHTNESS_LEVELS       = params_pkg::BRIGHTNESS_LEVELS,
    parameter int BRIGHTNESS_BASE_TIMEOUT = params_pkg::BRIGHTNESS_BASE_TIMEOUT,
    parameter int DIM_WIDTH               = 8,
    parameter int BLANK_CYCLES            = 2,
    parameter int STATE_TIMEOUT_OVERLAP   = 67
) (
    input  logic                         clk_in,
    input  logic                         reset_n,
    input  logic [BRIGHTNESS_LEVELS-1:0] brightness_mask_active,
    input  logic                         row_latch,
    input  logic [DIM_WIDTH-1:0]         global_dim,
    input  logic                         linear_mode,
    output logic                         output_enable,
    output logic                         busy,
    output logic                         done,
    output logic                         exceeded_overlap_time,
    output logic                         mask_error
);

    localparam int TIMEOUT_WIDTH =
        $clog2(BRIGHTNESS_BASE_TIMEOUT + 1) + BRIGHTNESS_LEVELS;
    localparam int TW = TIMEOUT_WIDTH;
    localparam int IW = (BRIGHTNESS_LEVELS > 1) ? $clog2(BRIGHTNESS_LEVELS) : 1;
    localparam int BW = (BLANK_CYCLES > 0) ? $clog2(BLANK_CYCLES + 1) : 1;
    localparam int PW = TW + DIM_WIDTH + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_BLANK,
        S_ON
    } state_t;

    state_t          state_q, state_d;
    logic [TW-1:0]   on_time_q, on_time_d;
    logic [TW-1:0]   elapsed_q, elapsed_d;
    logic [BW-1:0]   blank_cnt_q, blank_cnt_d;
    logic            row_latch_q;
    logic            armed_q, armed_d;
    logic            oe_q, oe_d;
    logic            done_q, done_d;
    logic            mask_err_q, mask_err_d;
    logic            latch_edge;

    logic [IW-1:0]   bit_idx;
    logic            one_hot;
    int              base_i;
    logic [TW-1:0]   base_t;
    logic [DIM_WIDTH:0] dim_p1;
    logic [PW-1:0]   prod;
    logic [TW-1:0]   scaled;
    logic [TW-1:0]   calc_time;

    // A rising edge only counts once row_latch has been seen low after reset.
    assign latch_edge = row_latch & ~row_latch_q & armed_q;
    assign armed_d    = armed_q | ~row_latch;

    always_comb begin
        bit_idx = '0;
        for (int i = BRIGHTNESS_LEVELS - 1; i >= 0; i--) begin
            if (brightness_mask_active[i]) bit_idx = IW'(i);
        end
        one_hot = $onehot(brightness_mask_active);
        if (linear_mode) base_i = BRIGHTNESS_BASE_TIMEOUT * (int'(bit_idx) + 1);
        else             base_i = BRIGHTNESS_BASE_TIMEOUT << bit_idx;
        base_t = TW'(base_i);
        dim_p1 = (DIM_WIDTH + 1)'(global_dim) + (DIM_WIDTH + 1)'(1);
        prod   = PW'(base_t) * PW'(dim_p1);
        scaled = TW'(prod >> DIM_WIDTH);
        if (!one_hot)                calc_time = TW'(1);
        else if (global_dim == '0)   calc_time = '0;
        else if (scaled == '0)       calc_time = TW'(1);
        else                         calc_time = scaled;
    end

    always_comb begin
        state_d     = state_q;
        on_time_d   = on_time_q;
        elapsed_d   = '0;
        blank_cnt_d = blank_cnt_q;
        done_d      = 1'b0;
        mask_err_d  = mask_err_q;
        if (latch_edge) begin
            on_time_d  = calc_time;
            mask_err_d = ~one_hot;
            if (BLANK_CYCLES == 0) begin
                if (calc_time == '0) begin
                    state_d = S_IDLE;
                end else begin
                    state_d   = S_ON;
                    elapsed_d = TW'(1);
                end
            end else begin
                state_d     = S_BLANK;
                blank_cnt_d = BW'(BLANK_CYCLES - 1);
            end
        end else begin
            unique case (state_q)
                S_IDLE: ;
                S_BLANK: begin
                    if (blank_cnt_q == '0) begin
                        if (on_time_q == '0) begin
                            state_d = S_IDLE;
                        end else begin
                            state_d   = S_ON;
                            elapsed_d = TW'(1);
                        end
                    end else begin
                        blank_cnt_d = blank_cnt_q - BW'(1);
                    end
                end
                S_ON: begin
                    if (elapsed_q >= on_time_q) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        elapsed_d = elapsed_q + TW'(1);
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
        oe_d = (state_d == S_ON);
    end

    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            on_time_q   <= '0;
            elapsed_q   <= '0;
            blank_cnt_q <= '0;
            row_latch_q <= 1'b0;
            armed_q     <= 1'b0;
            oe_q        <= 1'b0;
            done_q      <= 1'b0;
            mask_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            on_time_q   <= on_time_d;
            elapsed_q   <= elapsed_d;
            blank_cnt_q <= blank_cnt_d;
            row_latch_q <= row_latch;
            armed_q     <= armed_d;
            oe_q        <= oe_d;
            done_q      <= done_d;
            mask_err_q  <= mask_err_d;
        end
    end

    assign output_enable = oe_q;
    assign busy          = (state_q != S_IDLE);
    assign done          = done_q;
    assign mask_error    = mask_err_q;
    assign exceeded_overlap_time = (state_q == S_ON) &&
        (32'(elapsed_q) > 32'(STATE_TIMEOUT_OVERLAP));

endmodule
